// File: rtl/jedro_1_shift_pkg.sv
// rtl/jedro_1_shift_pkg.sv - shared types for the jedro_1 sequential shifter
package jedro_1_shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shifter_state_e;

endpackage

// File: rtl/jedro_1_shift_step.sv
// rtl/jedro_1_shift_step.sv - combinational partial shift by 0..STEP bits
module jedro_1_shift_step
  import jedro_1_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_W      = 6
) (
  input  shift_op_e              op,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [AMT_W-1:0]       amt,
  output logic [DATA_WIDTH-1:0]  res
);

  always_comb begin
    res = data;
    case (op)
      SLL: res = data << amt;
      SRL: res = data >> amt;
      SRA: res = DATA_WIDTH'($signed(data) >>> amt);
      // amt==0 shifts the wrap term by the full width, which yields zero
      ROR: res = (data >> amt) | (data << (DATA_WIDTH - int'(amt)));
      default: res = data;
    endcase
  end

endmodule

// File: rtl/jedro_1_seq_shifter.sv
// rtl/jedro_1_seq_shifter.sv - multi-cycle shift/rotate unit with valid/ready handshakes
module jedro_1_seq_shifter
  import jedro_1_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

  shifter_state_e        state;
  shift_op_e             op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SHAMT_W-1:0]    rem_q;
  logic [SHAMT_W:0]      rem_x;
  logic [SHAMT_W:0]      k;
  logic                  last_step;
  logic [DATA_WIDTH-1:0] step_res;

  assign rem_x      = {1'b0, rem_q};
  assign last_step  = (rem_x <= STEP_C);
  assign k          = last_step ? rem_x : STEP_C;
  assign in_ready_o = (state == IDLE) && !rst_i;
  assign res_o      = data_q;

  jedro_1_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMT_W      (SHAMT_W + 1)
  ) u_step (
    .op   (op_q),
    .data (data_q),
    .amt  (k),
    .res  (step_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      op_q        <= SLL;
      data_q      <= '0;
      rem_q       <= '0;
      out_valid_o <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_q   <= shift_op_e'(op_i);
            data_q <= data_i;
            rem_q  <= shamt_i;
            if (shamt_i == '0) begin
              state       <= DONE;
              out_valid_o <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= step_res;
          rem_q  <= rem_q - k[SHAMT_W-1:0];
          if (last_step) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
